// File: rtl/msrh_pkg.sv
// -----------------------------------------------------------------------------
// msrh_pkg
//   Shared rename-stage constants and helpers.
//   DISP_SIZE      : dispatch/commit lanes per cycle
//   FLIST_SIZE     : entries in one RNID free list
//   RNID_W         : width of a physical register ID
//   freelist_ptr_t : free-list pointer with wrap bit
//   popcount_disp  : number of set bits in a DISP_SIZE lane mask
// -----------------------------------------------------------------------------
package msrh_pkg;

   localparam int unsigned DISP_SIZE   = 4;
   localparam int unsigned FLIST_SIZE  = 32;
   localparam int unsigned RNID_W      = 7;
   localparam int unsigned FLIST_PTR_W = $clog2(FLIST_SIZE) + 1;
   localparam int unsigned DISP_CNT_W  = $clog2(DISP_SIZE) + 1;

   typedef logic [FLIST_PTR_W-1:0] freelist_ptr_t;

   function automatic logic [DISP_CNT_W-1:0] popcount_disp(input logic [DISP_SIZE-1:0] mask);
      logic [DISP_CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(DISP_SIZE); i++) begin
         cnt = cnt + DISP_CNT_W'(mask[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/msrh_lane_rank.sv
// -----------------------------------------------------------------------------
// msrh_lane_rank
//   Prefix popcount over a lane mask: o_rank[i] is the number of set bits
//   strictly below lane i, o_total the number of set bits overall. Used to
//   pack active lanes onto consecutive free-list slots.
//   i_mask  in  WIDTH           lane valid mask
//   o_rank  out WIDTH x CNT_W   exclusive prefix count per lane
//   o_total out CNT_W           popcount of i_mask
// -----------------------------------------------------------------------------
module msrh_lane_rank #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0]            i_mask,
   output logic [WIDTH-1:0][CNT_W-1:0] o_rank,
   output logic [CNT_W-1:0]            o_total
);

   logic [CNT_W-1:0] acc;

   always_comb begin
      acc    = '0;
      o_rank = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         o_rank[i] = acc;
         acc       = acc + CNT_W'(i_mask[i]);
      end
      o_total = acc;
   end

endmodule

// File: rtl/msrh_rnid_freelist.sv
// -----------------------------------------------------------------------------
// msrh_rnid_freelist
//   Multi-port circular free list of physical register IDs for rename.
//   Allocation is granted combinationally (all-or-nothing), frees are appended
//   at the tail, and a committed-head pointer lets a flush roll back every
//   speculative allocation in one cycle without moving any data.
//   i_clk         in   clock
//   i_reset       in   asynchronous reset, active-high
//   i_alloc_req   in   per-lane allocation request
//   o_alloc_ok    out  all requested lanes granted this cycle
//   o_alloc_rnid  out  RNID per lane, valid where req & ok
//   i_cmt_vld     in   lanes whose allocation retired
//   i_free_vld    in   lanes returning an RNID
//   i_free_rnid   in   returned RNIDs
//   i_flush       in   discard all uncommitted allocations
//   o_free_cnt    out  entries currently allocatable
//   o_empty       out  o_free_cnt == 0
// -----------------------------------------------------------------------------
module msrh_rnid_freelist
   import msrh_pkg::*;
#(
   parameter int unsigned DEPTH      = FLIST_SIZE,
   parameter int unsigned DISP_WIDTH = DISP_SIZE,
   parameter int unsigned RNID_W     = msrh_pkg::RNID_W,
   parameter int unsigned INIT_BASE  = 32
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [DISP_WIDTH-1:0]        i_alloc_req,
   output logic                         o_alloc_ok,
   output logic [DISP_WIDTH*RNID_W-1:0] o_alloc_rnid,
   input  logic [DISP_WIDTH-1:0]        i_cmt_vld,
   input  logic [DISP_WIDTH-1:0]        i_free_vld,
   input  logic [DISP_WIDTH*RNID_W-1:0] i_free_rnid,
   input  logic                         i_flush,
   output logic [$clog2(DEPTH):0]       o_free_cnt,
   output logic                         o_empty
);

   localparam int unsigned IDX_W      = $clog2(DEPTH);
   localparam int unsigned PTR_W      = IDX_W + 1;
   localparam int unsigned SUM_W      = PTR_W + 1;
   localparam int unsigned LANE_CNT_W = $clog2(DISP_WIDTH) + 1;

   typedef logic [PTR_W-1:0] ptr_t;

   logic [RNID_W-1:0] mem_q [DEPTH];
   ptr_t              head_q, head_d;
   ptr_t              cmt_head_q, cmt_head_d;
   ptr_t              tail_q, tail_d;
   ptr_t              head_adv;
   ptr_t              free_cnt;

   logic [DISP_WIDTH-1:0][LANE_CNT_W-1:0] alloc_rank, free_rank;
   logic [LANE_CNT_W-1:0]                 alloc_n, free_n, cmt_n;
   ptr_t                                  rd_ptr [DISP_WIDTH];
   ptr_t                                  wr_ptr [DISP_WIDTH];
   logic                                  alloc_ok;

   msrh_lane_rank #(
      .WIDTH (DISP_WIDTH),
      .CNT_W (LANE_CNT_W)
   ) u_alloc_rank (
      .i_mask  (i_alloc_req),
      .o_rank  (alloc_rank),
      .o_total (alloc_n)
   );

   msrh_lane_rank #(
      .WIDTH (DISP_WIDTH),
      .CNT_W (LANE_CNT_W)
   ) u_free_rank (
      .i_mask  (i_free_vld),
      .o_rank  (free_rank),
      .o_total (free_n)
   );

   always_comb begin
      cmt_n = '0;
      for (int i = 0; i < int'(DISP_WIDTH); i++) begin
         cmt_n = cmt_n + LANE_CNT_W'(i_cmt_vld[i]);
      end
   end

   // Modulo 2^(W+1) difference; the wrap bit disambiguates full from empty.
   assign free_cnt = tail_q - head_q;
   assign alloc_ok = !i_flush && (free_cnt >= ptr_t'(alloc_n));

   always_comb begin
      o_alloc_rnid = '0;
      for (int i = 0; i < int'(DISP_WIDTH); i++) begin
         rd_ptr[i] = head_q + ptr_t'(alloc_rank[i]);
         wr_ptr[i] = tail_q + ptr_t'(free_rank[i]);
         o_alloc_rnid[i*RNID_W +: RNID_W] = mem_q[rd_ptr[i][IDX_W-1:0]];
      end
   end

   always_comb begin
      head_adv   = alloc_ok ? head_q + ptr_t'(alloc_n) : head_q;
      cmt_head_d = cmt_head_q + ptr_t'(cmt_n);
      // Slots between cmt_head and head still hold their IDs, so rollback is a pointer move.
      head_d     = i_flush ? cmt_head_d : head_adv;
      tail_d     = tail_q + ptr_t'(free_n);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         head_q     <= '0;
         cmt_head_q <= '0;
         tail_q     <= ptr_t'(DEPTH);
         for (int k = 0; k < int'(DEPTH); k++) begin
            mem_q[k] <= RNID_W'(INIT_BASE + k);
         end
      end else begin
         head_q     <= head_d;
         cmt_head_q <= cmt_head_d;
         tail_q     <= tail_d;
         for (int i = 0; i < int'(DISP_WIDTH); i++) begin
            if (i_free_vld[i]) begin
               mem_q[wr_ptr[i][IDX_W-1:0]] <= i_free_rnid[i*RNID_W +: RNID_W];
            end
         end
      end
   end

   assign o_alloc_ok = alloc_ok;
   assign o_free_cnt = free_cnt;
   assign o_empty    = (free_cnt == '0);

   // Speculative span (head - cmt_head) must stay within the list; a negative
   // span shows up as a huge unsigned value.
   ptr_t spec_cnt_next;
   assign spec_cnt_next = head_adv - cmt_head_d;

   a_cmt_behind_head: assert property (@(posedge i_clk) disable iff (i_reset)
      spec_cnt_next <= ptr_t'(DEPTH));

   a_no_double_free: assert property (@(posedge i_clk) disable iff (i_reset)
      (SUM_W'(free_cnt) + SUM_W'(free_n)) <= SUM_W'(DEPTH));

endmodule

// File: tb/tb_msrh_rnid_freelist.sv
// -----------------------------------------------------------------------------
// tb_msrh_rnid_freelist
//   Reference model: queue of allocatable IDs (flist), queue of speculatively
//   allocated IDs (spec) and a pool of committed IDs that may be freed later.
// -----------------------------------------------------------------------------
module tb_msrh_rnid_freelist;

   localparam int DEPTH = 32;
   localparam int DW    = 4;
   localparam int RW    = 7;
   localparam int CW    = 6;
   localparam int BASE  = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [DW-1:0]    alloc_req = '0;
   logic [DW-1:0]    cmt_vld   = '0;
   logic [DW-1:0]    free_vld  = '0;
   logic [DW*RW-1:0] free_rnid = '0;
   logic             flush     = 1'b0;
   logic             alloc_ok;
   logic [DW*RW-1:0] alloc_rnid;
   logic [CW-1:0]    free_cnt;
   logic             empty;

   always #5 clk = ~clk;

   msrh_rnid_freelist #(
      .DEPTH      (DEPTH),
      .DISP_WIDTH (DW),
      .RNID_W     (RW),
      .INIT_BASE  (BASE)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_alloc_req  (alloc_req),
      .o_alloc_ok   (alloc_ok),
      .o_alloc_rnid (alloc_rnid),
      .i_cmt_vld    (cmt_vld),
      .i_free_vld   (free_vld),
      .i_free_rnid  (free_rnid),
      .i_flush      (flush),
      .o_free_cnt   (free_cnt),
      .o_empty      (empty)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int flist[$];
   int spec[$];
   int pool[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int lane_rnid(input int i);
      logic [DW*RW-1:0] v;
      v = alloc_rnid;
      return int'(v[i*RW +: RW]);
   endfunction

   function automatic logic [DW-1:0] rand_mask(input int c);
      logic [DW-1:0] m;
      m = '0;
      while ($countones(m) < c) m[$urandom_range(0, DW-1)] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      flist.delete();
      spec.delete();
      pool.delete();
      for (int k = 0; k < DEPTH; k++) begin
         flist.push_back(BASE + k);
         pool.push_back(k);
      end
   endtask

   // Compare the DUT against the model for the inputs currently applied.
   task automatic compare();
      int  n;
      int  r;
      bit  exp_ok;
      n      = $countones(alloc_req);
      exp_ok = !flush && (flist.size() >= n);
      check("alloc_ok", int'(alloc_ok), int'(exp_ok));
      check("free_cnt", int'(free_cnt), flist.size());
      check("empty", int'(empty), int'(flist.size() == 0));
      if (exp_ok) begin
         r = 0;
         for (int i = 0; i < DW; i++) begin
            if (alloc_req[i]) begin
               check($sformatf("alloc_rnid lane%0d", i), lane_rnid(i), flist[r]);
               r++;
            end
         end
      end
   endtask

   task automatic model_update();
      int  n;
      int  k;
      bit  ok;
      logic [DW*RW-1:0] fr;
      n  = $countones(alloc_req);
      k  = $countones(cmt_vld);
      ok = !flush && (flist.size() >= n);
      fr = free_rnid;
      if (ok) repeat (n) spec.push_back(flist.pop_front());
      repeat (k) pool.push_back(spec.pop_front());
      if (flush) while (spec.size() > 0) flist.push_front(spec.pop_back());
      for (int i = 0; i < DW; i++) begin
         if (free_vld[i]) flist.push_back(int'(fr[i*RW +: RW]));
      end
   endtask

   task automatic drive(input logic [DW-1:0] req, input logic [DW-1:0] cmt,
                        input logic [DW-1:0] fv, input logic fl);
      logic [DW*RW-1:0] fr;
      fr = '0;
      for (int i = 0; i < DW; i++) begin
         if (fv[i]) fr[i*RW +: RW] = RW'(pool.pop_front());
      end
      alloc_req = req;
      cmt_vld   = cmt;
      free_vld  = fv;
      free_rnid = fr;
      flush     = fl;
   endtask

   task automatic step(input logic [DW-1:0] req, input logic [DW-1:0] cmt,
                       input logic [DW-1:0] fv, input logic fl);
      drive(req, cmt, fv, fl);
      @(negedge clk);
      compare();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      alloc_req = '0;
      cmt_vld   = '0;
      free_vld  = '0;
      free_rnid = '0;
      flush     = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int fcnt0;
      int k;
      int allowed;
      int m;

      // Reset state and first allocation.
      do_reset();
      step(4'b0000, 4'b0000, 4'b0000, 1'b0);
      check("reset free_cnt", int'(free_cnt), 32);
      check("reset empty", int'(empty), 0);
      check("reset ok", int'(alloc_ok), 1);
      tick();
      step(4'b1111, 4'b0000, 4'b0000, 1'b0);
      check("t1 ok", int'(alloc_ok), 1);
      for (int i = 0; i < DW; i++) check($sformatf("t1 lane%0d", i), lane_rnid(i), 32 + i);
      tick();
      step(4'b0000, 4'b0000, 4'b0000, 1'b0);
      check("t1 cnt", int'(free_cnt), 28);
      tick();

      // Drain to empty; a request while empty stalls and head holds.
      do_reset();
      repeat (8) begin
         step(4'b1111, 4'b0000, 4'b0000, 1'b0);
         tick();
      end
      step(4'b0001, 4'b0000, 4'b0000, 1'b0);
      check("t2 empty", int'(empty), 1);
      check("t2 ok", int'(alloc_ok), 0);
      tick();
      step(4'b0000, 4'b0000, 4'b0000, 1'b0);
      check("t2 cnt held", int'(free_cnt), 0);
      tick();

      // Partial stall, then frees make the retry succeed one cycle later.
      do_reset();
      step(4'b1111, 4'b0000, 4'b0000, 1'b0);
      tick();
      repeat (6) begin
         step(4'b1111, 4'b1111, 4'b0000, 1'b0);
         tick();
      end
      step(4'b0011, 4'b1111, 4'b0000, 1'b0);
      tick();
      step(4'b0111, 4'b0000, 4'b0011, 1'b0);
      check("t3 stall ok", int'(alloc_ok), 0);
      check("t3 stall cnt", int'(free_cnt), 2);
      tick();
      step(4'b0111, 4'b0000, 4'b0000, 1'b0);
      check("t3 retry ok", int'(alloc_ok), 1);
      check("t3 retry cnt", int'(free_cnt), 4);
      tick();

      // Sparse lanes pack onto consecutive entries; sparse frees write in order.
      do_reset();
      step(4'b1010, 4'b0000, 4'b0000, 1'b0);
      check("t4 lane1", lane_rnid(1), 32);
      check("t4 lane3", lane_rnid(3), 33);
      tick();
      step(4'b0000, 4'b0011, 4'b0000, 1'b0);
      tick();
      step(4'b0000, 4'b0000, 4'b0101, 1'b0);
      tick();
      repeat (7) begin
         step(4'b1111, 4'b0000, 4'b0000, 1'b0);
         tick();
      end
      step(4'b1111, 4'b0000, 4'b0000, 1'b0);
      check("t4 freed lane0 id", lane_rnid(2), 0);
      check("t4 freed lane2 id", lane_rnid(3), 1);
      tick();

      // Steady alloc+free across the wrap boundary.
      do_reset();
      step(4'b1111, 4'b0000, 4'b0000, 1'b0);
      tick();
      step(4'b1111, 4'b1111, 4'b0000, 1'b0);
      tick();
      fcnt0 = 24;
      for (int j = 0; j < 20; j++) begin
         step(4'b1111, 4'b1111, 4'b1111, 1'b0);
         check($sformatf("t5 cnt it%0d", j), int'(free_cnt), fcnt0);
         tick();
      end

      // Flush rolls head back to committed head plus same-cycle commits.
      do_reset();
      repeat (3) begin
         step(4'b1111, 4'b0000, 4'b0000, 1'b0);
         tick();
      end
      step(4'b0000, 4'b1111, 4'b0000, 1'b0);
      tick();
      step(4'b0000, 4'b0001, 4'b0000, 1'b1);
      check("t6 flush ok", int'(alloc_ok), 0);
      tick();
      step(4'b1111, 4'b0000, 4'b0000, 1'b0);
      check("t6 cnt", int'(free_cnt), DEPTH - 5);
      for (int i = 0; i < DW; i++) check($sformatf("t6 lane%0d", i), lane_rnid(i), 37 + i);
      tick();

      // Randomized traffic with occasional flush and asynchronous reset.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         k = $urandom_range(0, (spec.size() < DW) ? spec.size() : DW);
         allowed = pool.size() + k - DEPTH;
         if (allowed > DW) allowed = DW;
         if (allowed < 0) allowed = 0;
         m = $urandom_range(0, allowed);
         step(DW'($urandom), rand_mask(k), rand_mask(m), ($urandom_range(0, 19) == 0));
         tick();
         if ($urandom_range(0, 399) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
